// File: rtl/conv_egress_tx.sv
// Egress AXI-Stream master for the convolution engine: buffers core result pixels in a small FIFO
// and tags each beat with SOF/EOL from frame position counters at push time.
package conv_pkg;
    parameter int PIXEL_W = 16;
endpackage

module conv_egress_tx #(
    parameter int PIXEL_W = conv_pkg::PIXEL_W,
    parameter int DIM_W   = 12,
    parameter int DEPTH   = 8,
    parameter int SKID    = 2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [DIM_W-1:0]   cfg_width_i,
    input  logic [DIM_W-1:0]   cfg_height_i,
    input  logic               res_vld_i,
    input  logic [PIXEL_W-1:0] res_data_i,
    output logic               res_rdy_o,
    output logic               m_tvalid_o,
    output logic [PIXEL_W-1:0] m_tdata_o,
    output logic               m_tuser_o,
    output logic               m_tlast_o,
    input  logic               m_tready_i,
    output logic               frame_done_o,
    output logic               err_ovf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic               sof;
        logic               eol;
        logic               eof;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head;
    entry_t           tag;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d, w_eff, h_eff;
    logic             err_q, err_d;
    logic             live_q;
    logic             push, pop, full, wr_en, frame_start;

    always_comb begin
        push        = res_vld_i;
        full        = (count_q == CW'(DEPTH));
        pop         = (count_q != '0) & m_tready_i;
        // When full, a simultaneous pop frees the slot being written this cycle.
        wr_en       = push & (~full | pop);
        frame_start = (col_q == '0) && (row_q == '0);

        // Shadow config is taken live on the first push of a frame and frozen thereafter.
        w_eff = frame_start ? cfg_width_i  : w_q;
        h_eff = frame_start ? cfg_height_i : h_q;

        tag.data = res_data_i;
        tag.sof  = frame_start;
        tag.eol  = (col_q == w_eff - 1'b1);
        tag.eof  = tag.eol && (row_q == h_eff - 1'b1);

        col_d = col_q;
        row_d = row_q;
        w_d   = w_q;
        h_d   = h_q;
        if (push) begin
            w_d = w_eff;
            h_d = h_eff;
            if (tag.eol) begin
                col_d = '0;
                row_d = tag.eof ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        wr_d = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d = pop   ? rd_q + 1'b1 : rd_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        err_d = err_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            col_q   <= col_d;
            row_q   <= row_d;
            w_q     <= w_d;
            h_q     <= h_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= tag;
        end
    end

    always_comb begin
        head         = mem_q[rd_q];
        m_tvalid_o   = (count_q != '0);
        m_tdata_o    = head.data;
        m_tuser_o    = m_tvalid_o & head.sof;
        m_tlast_o    = m_tvalid_o & head.eol;
        frame_done_o = pop & head.eof;
        res_rdy_o    = live_q & (count_q < CW'(DEPTH - SKID));
        err_ovf_o    = err_q;
    end

endmodule

// File: tb/tb_conv_egress_tx.sv
// Bench for conv_egress_tx: stimulus table, directed multi-cycle sequences and random traffic,
// all checked against a queue-based model that tags pixels from their linear index within a frame.
module tb_conv_egress_tx;

    localparam int PW    = 16;
    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic [DW-1:0] cfg_width_i = '0;
    logic [DW-1:0] cfg_height_i = '0;
    logic          res_vld_i = 1'b0;
    logic [PW-1:0] res_data_i = '0;
    logic          res_rdy_o;
    logic          m_tvalid_o;
    logic [PW-1:0] m_tdata_o;
    logic          m_tuser_o;
    logic          m_tlast_o;
    logic          m_tready_i = 1'b0;
    logic          frame_done_o;
    logic          err_ovf_o;

    always #5 clk = ~clk;

    conv_egress_tx #(
        .PIXEL_W (PW),
        .DIM_W   (DW),
        .DEPTH   (DEPTH),
        .SKID    (SKID)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .res_vld_i    (res_vld_i),
        .res_data_i   (res_data_i),
        .res_rdy_o    (res_rdy_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tdata_o    (m_tdata_o),
        .m_tuser_o    (m_tuser_o),
        .m_tlast_o    (m_tlast_o),
        .m_tready_i   (m_tready_i),
        .frame_done_o (frame_done_o),
        .err_ovf_o    (err_ovf_o)
    );

    typedef struct {
        logic [PW-1:0] data;
        bit            sof;
        bit            eol;
        bit            eof;
    } beat_t;

    typedef struct {
        bit            push;
        logic [PW-1:0] d;
        bit            rdy;
        bit            ev;
        logic [PW-1:0] ed;
        bit            eu;
        bit            el;
        bit            edn;
    } vec_t;

    beat_t       q[$];
    int unsigned idx, mw, mh;
    bit          merr;
    int unsigned tb_w, tb_h;
    int          passed = 0;
    int          total  = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // One clock cycle: drive, check DUT against the model, then advance the model.
    task automatic step(input bit push, input logic [PW-1:0] d, input bit rdy);
        beat_t       h, b;
        bit          mpop;
        int unsigned col, row;
        @(negedge clk);
        res_vld_i    = push;
        res_data_i   = d;
        m_tready_i   = rdy;
        cfg_width_i  = DW'(tb_w);
        cfg_height_i = DW'(tb_h);
        #1;
        chk("m_tvalid", m_tvalid_o, q.size() != 0);
        if (q.size() != 0) begin
            h = q[0];
            chk("m_tdata", m_tdata_o, h.data);
            chk("m_tuser", m_tuser_o, h.sof);
            chk("m_tlast", m_tlast_o, h.eol);
        end else begin
            chk("m_tuser_idle", m_tuser_o, 0);
            chk("m_tlast_idle", m_tlast_o, 0);
        end
        mpop = (q.size() != 0) && rdy;
        chk("frame_done", frame_done_o, mpop ? h.eof : 1'b0);
        chk("res_rdy", res_rdy_o, (DEPTH - q.size()) > SKID);
        chk("err_ovf", err_ovf_o, merr);
        if (mpop) void'(q.pop_front());
        if (push) begin
            if (idx == 0) begin
                mw = tb_w;
                mh = tb_h;
            end
            col    = idx % mw;
            row    = idx / mw;
            b.data = d;
            b.sof  = (idx == 0);
            b.eol  = (col == mw - 1);
            b.eof  = b.eol && (row == mh - 1);
            idx    = b.eof ? 0 : idx + 1;
            if (q.size() < DEPTH) q.push_back(b);
            else merr = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        res_vld_i  = 1'b0;
        m_tready_i = 1'b0;
        arst       = 1'b1;
        #1;
        chk("rst_rdy", res_rdy_o, 0);
        chk("rst_valid", m_tvalid_o, 0);
        chk("rst_user", m_tuser_o, 0);
        chk("rst_last", m_tlast_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_err", err_ovf_o, 0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        q.delete();
        idx  = 0;
        merr = 1'b0;
        @(posedge clk);
    endtask

    vec_t tbl[10];
    int   nlast, ndone;
    logic [13:0] lastmask;

    initial begin
        tb_w = 4;
        tb_h = 2;
        idx  = 0;
        merr = 0;
        do_reset();

        // Test 1: 4x2 frame streamed with tready held high.
        tbl[0] = '{1'b1, 16'h00A0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'h00A1, 1'b1, 1'b1, 16'h00A0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 16'h00A2, 1'b1, 1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'h00A3, 1'b1, 1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h00A4, 1'b1, 1'b1, 16'h00A3, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 16'h00A5, 1'b1, 1'b1, 16'h00A4, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 16'h00A6, 1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 16'h00A7, 1'b1, 1'b1, 16'h00A6, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A7, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].push, tbl[i].d, tbl[i].rdy);
            chk("t1_valid", m_tvalid_o, tbl[i].ev);
            if (tbl[i].ev) chk("t1_data", m_tdata_o, tbl[i].ed);
            chk("t1_user", m_tuser_o, tbl[i].eu);
            chk("t1_last", m_tlast_o, tbl[i].el);
            chk("t1_done", frame_done_o, tbl[i].edn);
        end

        // Tests 2/3: fill with tready low, skid pushes, then overflow and drain.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 16'h00B0 + PW'(i), 1'b0);
        step(1'b1, 16'h00B6, 1'b0);
        chk("t2_rdy_low_at6", res_rdy_o, 0);
        step(1'b1, 16'h00B7, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("t2_err_at8", err_ovf_o, 0);
        chk("t2_rdy_at8", res_rdy_o, 0);
        step(1'b1, 16'h00B8, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("t3_err_set", err_ovf_o, 1);
        nlast = 0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0000, 1'b1);
            if (m_tvalid_o && m_tlast_o) nlast++;
            if (frame_done_o) ndone++;
        end
        chk("t3_drain_lasts", nlast, 2);
        chk("t3_drain_done", ndone, 1);
        chk("t3_err_sticky", err_ovf_o, 1);

        // Test 4: full FIFO with simultaneous push and pop for 10 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'h00C0 + PW'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h00D0 + PW'(i), 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        chk("t4_err", err_ovf_o, 0);
        chk("t4_rdy_full", res_rdy_o, 0);
        for (int i = 0; i < 9; i++) step(1'b0, 16'h0000, 1'b1);
        chk("t4_empty", m_tvalid_o, 0);

        // Test 5: width changed mid-frame only takes effect at the next frame.
        do_reset();
        tb_w = 4;
        lastmask = '0;
        for (int k = 0; k < 15; k++) begin
            if (k == 2) tb_w = 3;
            step(k < 14, 16'h00E0 + PW'(k), 1'b1);
            if (k > 0) lastmask[k-1] = m_tlast_o;
        end
        chk("t5_last_pattern", lastmask, 14'h2488);

        // Width 1, height 1: every beat is SOF, EOL and end of frame.
        do_reset();
        tb_w  = 1;
        tb_h  = 1;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            step(k < 4, 16'h0010 + PW'(k), 1'b1);
            if (frame_done_o) ndone++;
        end
        chk("w1h1_done_count", ndone, 4);

        // Test 6: reset with entries queued mid-frame.
        do_reset();
        tb_w = 4;
        tb_h = 2;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h00F0 + PW'(i), 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("t6_valid_before", m_tvalid_o, 1);
        arst = 1'b1;
        #1;
        chk("t6_valid_async", m_tvalid_o, 0);
        chk("t6_rdy_async", res_rdy_o, 0);
        @(negedge clk);
        arst = 1'b0;
        q.delete();
        idx  = 0;
        merr = 1'b0;
        @(posedge clk);
        step(1'b1, 16'h0077, 1'b0);
        step(1'b0, 16'h0000, 1'b1);
        chk("t6_sof_after", m_tuser_o, 1);
        chk("t6_data_after", m_tdata_o, 16'h0077);

        // Random traffic with occasional config changes (ignored mid-frame).
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                tb_w = $urandom_range(1, 5);
                tb_h = $urandom_range(1, 4);
            end
            step($urandom_range(0, 9) < 6, PW'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
